// File: rtl/psk_pkg.sv
// Shared types and helpers for the PSK transmit mixer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package psk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

    // Widest sample the helper below can handle; callers sign-extend into it.
    localparam int SAT_MAX_W = 64;

    // Two's complement negation of a width-bit value (sign-extended into x)
    // that maps the most negative code to the most positive one instead of
    // wrapping back onto itself.
    function automatic logic signed [SAT_MAX_W-1:0] sat_neg(
        input logic signed [SAT_MAX_W-1:0] x,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] min_v;
        min_v = {SAT_MAX_W{1'b1}} << (width - 1);
        if (x == min_v) begin
            return ~min_v;
        end
        return -x;
    endfunction

endpackage

// File: rtl/psk_map.sv
// Symbol-to-sample mapper: BPSK phase flip or QPSK I/Q sum, saturating.
// Latency: one cycle from load to psk_out/out_valid.
// Backpressure: none; the parent decides when a sample is loaded or zeroed.
module psk_map
    import psk_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             vld,
    input  logic             force_zero,
    input  logic             mode,
    input  logic [1:0]       sym,
    input  logic [WIDTH-1:0] sine,
    input  logic [WIDTH-1:0] cosine,
    output logic [WIDTH-1:0] psk_out,
    output logic             out_valid
);

    logic [WIDTH-1:0]      neg_sine;
    logic [WIDTH-1:0]      neg_cos;
    logic [WIDTH-1:0]      i_v;
    logic [WIDTH-1:0]      q_v;
    logic [WIDTH-1:0]      mapped;
    logic signed [WIDTH:0] iq_sum;

    // Map the current symbol onto this carrier sample; the QPSK sum is one bit
    // wider so halving it can never overflow.
    always_comb begin
        neg_sine = WIDTH'(sat_neg(SAT_MAX_W'(signed'(sine)), WIDTH));
        neg_cos  = WIDTH'(sat_neg(SAT_MAX_W'(signed'(cosine)), WIDTH));
        i_v      = sym[0] ? neg_cos : cosine;
        q_v      = sym[1] ? neg_sine : sine;
        iq_sum   = {i_v[WIDTH-1], i_v} + {q_v[WIDTH-1], q_v};
        if (mode == MODE_BPSK) begin
            mapped = sym[0] ? neg_sine : sine;
        end else begin
            mapped = WIDTH'(iq_sum >>> 1);
        end
    end

    // Output register: psk_out holds between loads, out_valid is per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            psk_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vld;
            if (load) begin
                psk_out <= force_zero ? '0 : mapped;
            end
        end
    end

endmodule

// File: rtl/psk_mixer.sv
// Transmit-path PSK mixer: holds each symbol for SPS carrier samples.
// Latency: carrier sample to psk_out one cycle; accepted symbol first shows two cycles later.
// Backpressure: bit_ready only in IDLE or at the symbol boundary, never from bit_valid.
module psk_mixer
    import psk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SPS   = 64,
    parameter int DIFF  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mod_ena,
    input  logic             mode,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] sine,
    input  logic [WIDTH-1:0] cosine,
    input  logic [1:0]       bit_data,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             ena_mod,
    output logic [WIDTH-1:0] psk_out,
    output logic             out_valid,
    output logic             underrun
);

    localparam int CNT_W = $clog2(SPS);

    state_t           state;
    logic [CNT_W-1:0] sym_cnt;
    logic [1:0]       sym_bits;
    logic [1:0]       prev_bits;
    logic [1:0]       enc_bits;
    logic             sym_mode;
    logic             sym_last;
    logic             xfer;
    logic             map_load;
    logic             map_vld;
    logic             map_zero;

    assign sym_last = (sym_cnt == CNT_W'(SPS - 1));
    assign enc_bits = (DIFF != 0) ? (bit_data ^ prev_bits) : bit_data;
    assign xfer     = bit_ready & bit_valid;

    // Ready only where a symbol may start: idle with a strobe, or the last sample.
    always_comb begin
        bit_ready = 1'b0;
        case (state)
            IDLE:    bit_ready = mod_ena & sample_en;
            RUN:     bit_ready = mod_ena & sample_en & sym_last;
            default: bit_ready = 1'b0;
        endcase
    end

    // Mapper control: modulate in RUN, one forced valid zero in DRAIN, silent zero in IDLE.
    always_comb begin
        map_load = sample_en;
        map_vld  = 1'b0;
        map_zero = 1'b1;
        case (state)
            RUN: begin
                map_vld  = sample_en;
                map_zero = 1'b0;
            end
            DRAIN: begin
                map_load = 1'b1;
                map_vld  = 1'b1;
            end
            default: ;
        endcase
    end

    // Symbol sequencing: load, count samples, and decide at each boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sym_cnt   <= '0;
            sym_bits  <= '0;
            prev_bits <= '0;
            sym_mode  <= MODE_BPSK;
            ena_mod   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sym_bits  <= enc_bits;
                        prev_bits <= enc_bits;
                        sym_mode  <= mode;
                        sym_cnt   <= '0;
                        state     <= RUN;
                        ena_mod   <= 1'b1;
                    end
                end
                RUN: begin
                    if (sample_en) begin
                        if (!sym_last) begin
                            sym_cnt <= sym_cnt + 1'b1;
                        end else if (!mod_ena) begin
                            sym_cnt <= '0;
                            state   <= DRAIN;
                            ena_mod <= 1'b0;
                        end else if (bit_valid) begin
                            sym_bits  <= enc_bits;
                            prev_bits <= enc_bits;
                            sym_mode  <= mode;
                            sym_cnt   <= '0;
                        end else begin
                            underrun  <= 1'b1;
                            sym_cnt   <= '0;
                            prev_bits <= '0;
                            state     <= IDLE;
                            ena_mod   <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    prev_bits <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ena_mod <= 1'b0;
                end
            endcase
        end
    end

    psk_map #(
        .WIDTH(WIDTH)
    ) u_map (
        .clk        (clk),
        .rst        (rst),
        .load       (map_load),
        .vld        (map_vld),
        .force_zero (map_zero),
        .mode       (sym_mode),
        .sym        (sym_bits),
        .sine       (sine),
        .cosine     (cosine),
        .psk_out    (psk_out),
        .out_valid  (out_valid)
    );

endmodule

// File: tb/tb_psk_mixer.sv
// Bench for psk_mixer: directed symbol streams, expected samples queued per instance.
// Latency: checks one-cycle sample latency and the two-cycle symbol start.
// Backpressure: symbols are held on bit_valid until bit_ready is seen.
module tb_psk_mixer;

    logic        clk       = 1'b0;
    logic        rst0      = 1'b1;
    logic        rst1      = 1'b1;
    logic        mod_ena   = 1'b0;
    logic        mode      = 1'b0;
    logic        sample_en = 1'b1;
    logic        bit_valid = 1'b0;
    logic [1:0]  bit_data  = 2'b00;
    logic [15:0] sine      = 16'h0000;
    logic [15:0] cosine    = 16'h0000;
    logic        gap       = 1'b0;
    logic        sel       = 1'b0;

    logic [15:0] psk_out0, psk_out1;
    logic        bit_ready0, bit_ready1, ena_mod0, ena_mod1;
    logic        out_valid0, out_valid1, underrun0, underrun1;

    int          cyc    = 0;
    int          total  = 0;
    int          passed = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    psk_mixer #(.WIDTH(16), .SPS(4), .DIFF(0)) dut0 (
        .clk(clk), .rst(rst0), .mod_ena(mod_ena), .mode(mode), .sample_en(sample_en),
        .sine(sine), .cosine(cosine), .bit_data(bit_data), .bit_valid(bit_valid),
        .bit_ready(bit_ready0), .ena_mod(ena_mod0), .psk_out(psk_out0),
        .out_valid(out_valid0), .underrun(underrun0)
    );

    psk_mixer #(.WIDTH(16), .SPS(4), .DIFF(1)) dut1 (
        .clk(clk), .rst(rst1), .mod_ena(mod_ena), .mode(mode), .sample_en(sample_en),
        .sine(sine), .cosine(cosine), .bit_data(bit_data), .bit_valid(bit_valid),
        .bit_ready(bit_ready1), .ena_mod(ena_mod1), .psk_out(psk_out1),
        .out_valid(out_valid1), .underrun(underrun1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h, required %h", name, got, exp);
        else passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic s, input logic [15:0] v, input int n);
        repeat (n) begin
            if (s) q1.push_back(v);
            else   q0.push_back(v);
        end
    endtask

    task automatic send(input logic [1:0] b);
        int n = 0;
        bit_data  = b;
        bit_valid = 1'b1;
        @(negedge clk);
        while (!(sel ? bit_ready1 : bit_ready0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(sel ? bit_ready1 : bit_ready0)) $display("FAIL send_ready: bit_ready stayed 0 for %0d cycles, required 1", n);
        else passed++;
        @(posedge clk);
        #2;
        bit_valid = 1'b0;
    endtask

    task automatic wait_empty(input logic s);
        int n = 0;
        while ((s ? q1.size() : q0.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ((s ? q1.size() : q0.size()) != 0)
            $display("FAIL drain_wait dut%0d: %0d outputs pending, required 0", s, (s ? q1.size() : q0.size()));
        else passed++;
        tick(2);
    endtask

    // Carrier strobe: every cycle, or every third cycle in gapped mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            sample_en = gap ? (cyc % 3 == 0) : 1'b1;
        end
    end

    // Scoreboard monitors: every valid output must match the next queued sample.
    always @(negedge clk) begin
        if (out_valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL dut0_extra_output: got %h, required no output", psk_out0);
            end else begin
                check("dut0_psk_out", {16'h0, psk_out0}, {16'h0, q0.pop_front()});
            end
        end
        if (out_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL dut1_extra_output: got %h, required no output", psk_out1);
            end else begin
                check("dut1_psk_out", {16'h0, psk_out1}, {16'h0, q1.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(2);
        check("rst_psk_out0",   {16'h0, psk_out0}, 32'h0);
        check("rst_out_valid0", {31'h0, out_valid0}, 32'h0);
        check("rst_ena_mod0",   {31'h0, ena_mod0}, 32'h0);
        check("rst_bit_ready0", {31'h0, bit_ready0}, 32'h0);
        check("rst_underrun0",  {31'h0, underrun0}, 32'h0);
        check("rst_psk_out1",   {16'h0, psk_out1}, 32'h0);
        check("rst_out_valid1", {31'h0, out_valid1}, 32'h0);
        rst0 = 1'b0;
        tick(1);

        // BPSK basic, then mod_ena drop at sym_cnt = 1 of the second symbol
        sel = 1'b0; sine = 16'h0001; cosine = 16'h0000; mode = 1'b0; mod_ena = 1'b1;
        push(0, 16'h0001, 4); push(0, 16'hFFFF, 4); push(0, 16'h0000, 1);
        send(2'b00);
        check("start_ena_mod", {31'h0, ena_mod0}, 32'h1);
        check("start_no_valid_yet", {31'h0, out_valid0}, 32'h0);
        tick(1);
        check("first_out_latency", {31'h0, out_valid0}, 32'h1);
        send(2'b01);
        tick(1);
        mod_ena = 1'b0;
        tick(2);
        check("no_truncate_ena_mod", {31'h0, ena_mod0}, 32'h1);
        tick(1);
        check("drain_ena_mod_low", {31'h0, ena_mod0}, 32'h0);
        tick(2);
        check("post_drain_valid", {31'h0, out_valid0}, 32'h0);
        check("post_drain_ready", {31'h0, bit_ready0}, 32'h0);
        wait_empty(0);

        // Saturation; mode changes mid-symbol only apply at the next symbol
        sine = 16'h8000; cosine = 16'h8000; mode = 1'b0; mod_ena = 1'b1;
        push(0, 16'h7FFF, 8); push(0, 16'hFFFF, 4); push(0, 16'h0000, 1);
        send(2'b01);
        mode = 1'b1;
        send(2'b11);
        send(2'b01);
        mod_ena = 1'b0;
        wait_empty(0);
        check("sat_idle_ena_mod", {31'h0, ena_mod0}, 32'h0);
        sine = 16'h7FFF; cosine = 16'h7FFF; mode = 1'b1; mod_ena = 1'b1;
        push(0, 16'h7FFF, 4);
        send(2'b00);

        // Underrun at the boundary with mod_ena still high
        tick(3);
        check("underrun_before_boundary", {31'h0, underrun0}, 32'h0);
        tick(1);
        check("underrun_set", {31'h0, underrun0}, 32'h1);
        check("underrun_idle", {31'h0, ena_mod0}, 32'h0);
        tick(1);
        check("underrun_zero_out", {16'h0, psk_out0}, 32'h0);
        check("underrun_no_valid", {31'h0, out_valid0}, 32'h0);
        mode = 1'b0;
        push(0, 16'h8001, 4); push(0, 16'h0000, 1);
        send(2'b01);
        mod_ena = 1'b0;
        wait_empty(0);
        check("underrun_sticky", {31'h0, underrun0}, 32'h1);

        // Gapped strobes, reset at sym_cnt = 2
        gap = 1'b1; sine = 16'h1234; mode = 1'b0; mod_ena = 1'b1;
        push(0, 16'h1234, 2);
        send(2'b00);
        check("underrun_sticky_restart", {31'h0, underrun0}, 32'h1);
        tick(3);
        check("gap_first_valid", {31'h0, out_valid0}, 32'h1);
        tick(1);
        check("gap_valid_low", {31'h0, out_valid0}, 32'h0);
        check("gap_hold_psk", {16'h0, psk_out0}, 32'h1234);
        tick(2);
        rst0 = 1'b1; mod_ena = 1'b0;
        tick(1);
        check("midrst_psk_out", {16'h0, psk_out0}, 32'h0);
        check("midrst_out_valid", {31'h0, out_valid0}, 32'h0);
        check("midrst_ena_mod", {31'h0, ena_mod0}, 32'h0);
        check("midrst_underrun", {31'h0, underrun0}, 32'h0);
        check("midrst_bit_ready", {31'h0, bit_ready0}, 32'h0);
        rst0 = 1'b0; mod_ena = 1'b1;
        push(0, 16'hEDCC, 4); push(0, 16'h0000, 1);
        send(2'b01);
        mod_ena = 1'b0;
        wait_empty(0);

        // Differential encoding with a mid-symbol mode switch
        gap = 1'b0; rst0 = 1'b1; rst1 = 1'b0; sel = 1'b1;
        tick(1);
        sine = 16'h0100; cosine = 16'h0300; mode = 1'b0; mod_ena = 1'b1;
        push(1, 16'hFF00, 4); push(1, 16'h0100, 8); push(1, 16'hFE00, 4);
        push(1, 16'hFF00, 4); push(1, 16'h0000, 1);
        send(2'b01);
        send(2'b01);
        send(2'b00);
        tick(1);
        mode = 1'b1;
        send(2'b11);
        send(2'b10);
        mod_ena = 1'b0;
        wait_empty(1);
        mode = 1'b0; mod_ena = 1'b1;
        push(1, 16'h0100, 4); push(1, 16'h0000, 1);
        send(2'b00);
        mod_ena = 1'b0;
        wait_empty(1);
        check("diff_end_ena_mod", {31'h0, ena_mod1}, 32'h0);

        tick(4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/psk_mixer.md
# psk_mixer

Parametrised successor to the single-channel BPSK mixer, placed between the carrier NCO (sine/cosine samples) and the DAC interface in the transmit path. It takes symbols from the modulator controller over a valid/ready handshake and holds each one for a programmable number of carrier samples. It outputs the carrier either phase-flipped (BPSK) or I/Q-combined (QPSK), with saturating arithmetic. Controlled start and drain, differential encoding and underrun reporting are behaviours the previous mixer did not have.

## Interface
- WIDTH, 16, carrier and output sample width, signed two's complement
- SPS, 64, carrier samples per symbol, ≥2
- DIFF, 0, 1 = differential encoding of symbols before mapping
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- mod_ena  in  1  modulation enable from controller
- mode  in  1  0 = BPSK, 1 = QPSK; sampled only at symbol load
- sample_en  in  1  carrier sample strobe; sine/cosine valid this cycle
- sine  in  WIDTH  carrier sine sample
- cosine  in  WIDTH  carrier cosine sample (ignored in BPSK)
- bit_data  in  2  symbol bits; [0] = I (BPSK uses [0] only), [1] = Q
- bit_valid  in  1  bit_data valid
- bit_ready  out  1  mixer accepts a symbol this cycle
- ena_mod  out  1  high while a symbol is being transmitted
- psk_out  out  WIDTH  modulated sample
- out_valid  out  1  psk_out updated this cycle
- underrun  out  1  sticky; no symbol available at a symbol boundary

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - bit_ready = mod_ena & sample_en.
  - A transfer (bit_ready & bit_valid) loads the symbol register, clears sym_cnt to 0 and enters RUN.
- RUN:
  - Each sample_en increments sym_cnt.
  - At sym_cnt == SPS-1 with sample_en (the boundary):
    - If mod_ena: bit_ready = 1. A transfer loads the next symbol and wraps sym_cnt to 0. No transfer sets underrun, enters IDLE, and forces psk_out to 0 from the next sample.
    - If !mod_ena: bit_ready = 0, go to DRAIN.
- DRAIN: emits one cycle of psk_out = 0 with out_valid, then enters IDLE.
- mod_ena falling mid-symbol never truncates the symbol: the current symbol completes all SPS samples.
- mode is latched with each symbol, so a mode change takes effect only at a symbol boundary.
- Differential encoding (DIFF=1): loaded bits = new bits XOR previous loaded bits, per lane. The previous bits are cleared to 0 by rst and on entry to IDLE.
- BPSK mapping:
  - bit 0 → +sine, bit 1 → −sine.
  - Negation saturates: −(−2^(WIDTH−1)) = 2^(WIDTH−1)−1.
- QPSK mapping:
  - i = ±cosine (I bit), q = ±sine (Q bit), each with saturating negation.
  - Sum at WIDTH+1 bits, arithmetic shift right 1, truncate to WIDTH. No overflow is possible.
- ena_mod = state is RUN.
- underrun is cleared only by rst.

## Timing
- Reset values: psk_out = 0, out_valid = 0, ena_mod = 0, bit_ready = 0, underrun = 0; state IDLE, sym_cnt = 0, symbol and previous-bit registers = 0.
- bit_ready is combinational from state, sym_cnt, mod_ena and sample_en. It never depends on bit_valid.
- Latency: sample on sine/cosine with sample_en at cycle n → psk_out/out_valid registered at n+1.
- A symbol accepted at cycle n modulates the sample presented at n+1 onward. The first output of the new symbol appears at n+2.
- Within RUN, out_valid mirrors sample_en delayed one cycle. In IDLE out_valid = 0, except for the DRAIN zero sample.
- Cycles without sample_en hold psk_out and sym_cnt.
- rst overrides everything, including mid-symbol and during a transfer; the accepted symbol is discarded.

## Structure
- Package psk_pkg:
  - state enum (IDLE, RUN, DRAIN)
  - mode constants MODE_BPSK = 0, MODE_QPSK = 1
  - function sat_neg(WIDTH).
- One sub-module, psk_map: registered symbol-to-sample mapper (BPSK/QPSK, saturating negation, QPSK sum/shift).
- The FSM, sym_cnt ($clog2(SPS) bits) and differential encoder stay in psk_mixer.

## Test plan
- **BPSK basic:** WIDTH=16, SPS=4, sample_en = 1 every cycle, sine = 1, bit_data stream 0,1 → four samples of psk_out = 1, then four of −1 (0xFFFF); ena_mod high throughout.
- **Saturation:** sine = 0x8000, bit 1 → psk_out = 0x7FFF. QPSK with cosine = sine = 0x7FFF and bits I=0, Q=0 → 0x7FFF. I=1, Q=1 with both 0x8000 → 0x7FFF.
- **Drain:** drop mod_ena at sym_cnt = 1 → the symbol completes (2 more samples), then one zero sample with out_valid, then ena_mod = 0 and bit_ready = 0.
- **Underrun:** hold bit_valid = 0 at a boundary with mod_ena = 1 → underrun = 1 and stays 1, psk_out = 0, state IDLE; the next transfer restarts cleanly.
- **Differential + mode switch:** DIFF=1, BPSK, bits 1,1,0 → phases −,+,+. Switching mode mid-symbol applies only at the next boundary.
- **Reset mid-symbol with gapped sample_en:** sample_en every 3rd cycle → sym_cnt advances only on strobes. rst at sym_cnt = 2 → all outputs 0 next cycle, state IDLE.
